// File: rtl/blowfish128_pkg.sv
// Shared Blowfish-128 key-schedule constants and FSM state type.
// No logic; latency and backpressure do not apply.
package blowfish128_pkg;

    localparam int NUM_P         = 20;
    localparam int MAX_KEY_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fractional hex digits of pi, P1 first.
    localparam logic [31:0] PI [NUM_P] = '{
        32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
        32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
        32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
        32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917,
        32'h9216D5D9, 32'h8979FB1B, 32'hD1310BA6, 32'h98DFB5AC
    };

endpackage

// File: rtl/blowfish128_keyword_sel.sv
// Selects 32-bit key word K[ptr] from the latched key and clamps key_length to 1..8.
// Purely combinational, zero latency; no backpressure.
module blowfish128_keyword_sel
    import blowfish128_pkg::*;
(
    input  logic [MAX_KEY_WORDS-1:0][63:0] key,
    input  logic [3:0]                     ptr,
    input  logic [3:0]                     key_length,
    output logic [3:0]                     len_clamped,
    output logic [31:0]                    kword
);

    always_comb begin
        len_clamped = key_length;
        if (key_length == 4'd0) begin
            len_clamped = 4'd1;
        end else if (key_length > 4'd8) begin
            len_clamped = 4'd8;
        end
    end

    // Even word index takes the high half of the 64-bit key word.
    assign kword = ptr[0] ? key[ptr[3:1]][31:0] : key[ptr[3:1]][63:32];

endmodule

// File: rtl/blowfish128_skeygen.sv
// Blowfish-128 P-array key mixing: one P entry per clock, skey_ready 20 edges after Enable is sampled.
// Enable is a level request; dropping it aborts or releases the result, no other flow control.
module blowfish128_skeygen
    import blowfish128_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Enable,
    input  logic [63:0] key0,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    input  logic [63:0] key4,
    input  logic [63:0] key5,
    input  logic [63:0] key6,
    input  logic [63:0] key7,
    input  logic [3:0]  key_length,
    output logic        skey_ready,
    output logic [31:0] P1,
    output logic [31:0] P2,
    output logic [31:0] P3,
    output logic [31:0] P4,
    output logic [31:0] P5,
    output logic [31:0] P6,
    output logic [31:0] P7,
    output logic [31:0] P8,
    output logic [31:0] P9,
    output logic [31:0] P10,
    output logic [31:0] P11,
    output logic [31:0] P12,
    output logic [31:0] P13,
    output logic [31:0] P14,
    output logic [31:0] P15,
    output logic [31:0] P16,
    output logic [31:0] P17,
    output logic [31:0] P18,
    output logic [31:0] P19,
    output logic [31:0] P20
);

    state_t                         state;
    state_t                         next_state;
    logic                           load;
    logic                           write;
    logic [4:0]                     index;
    logic [3:0]                     ptr;
    logic [MAX_KEY_WORDS-1:0][63:0] key_lat;
    logic [3:0]                     len_lat;
    logic [3:0]                     len_clamped;
    logic [4:0]                     word_cnt;
    logic [31:0]                    kword;
    logic [NUM_P-1:0][31:0]         p_reg;

    blowfish128_keyword_sel u_keyword_sel (
        .key         (key_lat),
        .ptr         (ptr),
        .key_length  (key_length),
        .len_clamped (len_clamped),
        .kword       (kword)
    );

    assign word_cnt = {len_lat, 1'b0};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (Enable) next_state = MIX;
            MIX: begin
                if (!Enable) begin
                    next_state = IDLE;
                end else if (index == 5'(NUM_P - 1)) begin
                    next_state = DONE;
                end
            end
            DONE: if (!Enable) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load       = 1'b0;
        write      = 1'b0;
        skey_ready = 1'b0;
        case (state)
            IDLE:    load       = Enable;
            MIX:     write      = Enable;
            DONE:    skey_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            key_lat <= '0;
            len_lat <= '0;
            index   <= '0;
            ptr     <= '0;
            p_reg   <= '0;
        end else if (load) begin
            key_lat <= {key7, key6, key5, key4, key3, key2, key1, key0};
            len_lat <= len_clamped;
            index   <= '0;
            ptr     <= '0;
        end else if (write) begin
            p_reg[index] <= PI[index] ^ kword;
            index        <= index + 5'd1;
            // Key words are reused cyclically once all W have been consumed.
            ptr          <= (({1'b0, ptr} + 5'd1) == word_cnt) ? 4'd0 : ptr + 4'd1;
        end
    end

    assign P1  = p_reg[0];
    assign P2  = p_reg[1];
    assign P3  = p_reg[2];
    assign P4  = p_reg[3];
    assign P5  = p_reg[4];
    assign P6  = p_reg[5];
    assign P7  = p_reg[6];
    assign P8  = p_reg[7];
    assign P9  = p_reg[8];
    assign P10 = p_reg[9];
    assign P11 = p_reg[10];
    assign P12 = p_reg[11];
    assign P13 = p_reg[12];
    assign P14 = p_reg[13];
    assign P15 = p_reg[14];
    assign P16 = p_reg[15];
    assign P17 = p_reg[16];
    assign P18 = p_reg[17];
    assign P19 = p_reg[18];
    assign P20 = p_reg[19];

endmodule

// File: tb/tb_blowfish128_skeygen.sv
// Directed and randomized checks of blowfish128_skeygen against a behavioural P-array model.
module tb_blowfish128_skeygen;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Enable;
    logic [63:0] kin [8];
    logic [3:0]  key_length;
    logic        skey_ready;
    logic [31:0] P1, P2, P3, P4, P5, P6, P7, P8, P9, P10;
    logic [31:0] P11, P12, P13, P14, P15, P16, P17, P18, P19, P20;
    logic [31:0] dp [20];

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] PI_REF [20] = '{
        32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
        32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
        32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
        32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917,
        32'h9216D5D9, 32'h8979FB1B, 32'hD1310BA6, 32'h98DFB5AC
    };

    blowfish128_skeygen dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable),
        .key0(kin[0]), .key1(kin[1]), .key2(kin[2]), .key3(kin[3]),
        .key4(kin[4]), .key5(kin[5]), .key6(kin[6]), .key7(kin[7]),
        .key_length(key_length), .skey_ready(skey_ready),
        .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5),
        .P6(P6), .P7(P7), .P8(P8), .P9(P9), .P10(P10),
        .P11(P11), .P12(P12), .P13(P13), .P14(P14), .P15(P15),
        .P16(P16), .P17(P17), .P18(P18), .P19(P19), .P20(P20)
    );

    always #5 Clk = ~Clk;

    always_comb begin
        dp[0]  = P1;  dp[1]  = P2;  dp[2]  = P3;  dp[3]  = P4;  dp[4]  = P5;
        dp[5]  = P6;  dp[6]  = P7;  dp[7]  = P8;  dp[8]  = P9;  dp[9]  = P10;
        dp[10] = P11; dp[11] = P12; dp[12] = P13; dp[13] = P14; dp[14] = P15;
        dp[15] = P16; dp[16] = P17; dp[17] = P18; dp[18] = P19; dp[19] = P20;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pi = PI[i] ^ K[(i-1) mod 2L], with K the key split into 32-bit words, high half first.
    function automatic logic [31:0] model_p(input int i, input logic [63:0] k [8], input logic [3:0] len);
        int l;
        int w;
        int idx;
        logic [63:0] kw64;
        l    = (len == 0) ? 1 : ((len > 8) ? 8 : int'(len));
        w    = 2 * l;
        idx  = i % w;
        kw64 = k[idx / 2];
        return PI_REF[i] ^ ((idx % 2 == 1) ? kw64[31:0] : kw64[63:32]);
    endfunction

    task automatic check_all(input string tag, input logic [63:0] k [8], input logic [3:0] len);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("%s P%0d", tag, i + 1), dp[i], model_p(i, k, len));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " ready"}, {31'b0, skey_ready}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("%s P%0d", tag, i + 1), dp[i], 32'd0);
        end
    endtask

    // Starts generation from IDLE and checks latency and the full P-array.
    task automatic run_gen(input string tag, input bit scramble);
        logic [63:0] ks [8];
        logic [3:0]  ls;
        int          lat;
        ks     = kin;
        ls     = key_length;
        Enable = 1'b1;
        step();
        lat = 0;
        while (skey_ready !== 1'b1 && lat < 40) begin
            step();
            lat++;
            if (scramble && lat == 3) begin
                for (int j = 0; j < 8; j++) kin[j] = {$urandom, $urandom};
                key_length = 4'($urandom_range(0, 15));
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'd20);
        check_all(tag, ks, ls);
    endtask

    task automatic release_en();
        Enable = 1'b0;
        step();
    endtask

    task automatic set_plan_keys();
        kin[0] = 64'h0123456789ABCDEF;
        kin[1] = 64'hFEDCBA9876543210;
        kin[2] = 64'h0011223344556677;
        kin[3] = 64'h8899AABBCCDDEEFF;
        for (int j = 4; j < 8; j++) kin[j] = {$urandom, $urandom};
    endtask

    initial begin
        logic [31:0] prev [20];
        logic [63:0] ks [8];

        Rst        = 1'b1;
        Enable     = 1'b0;
        key_length = 4'd0;
        for (int j = 0; j < 8; j++) kin[j] = 64'd0;
        step();
        step();
        check_zero("reset");
        Rst = 1'b0;

        set_plan_keys();
        key_length = 4'd4;
        run_gen("len4", 1'b0);
        chk("len4 lit P1", P1, 32'h251C2FEF);
        chk("len4 lit P2", P2, 32'h0C08C53C);
        chk("len4 lit P9", P9, 32'h440B6481);
        chk("len4 lit P20", P20, 32'hEE8B87BC);
        release_en();
        chk("release ready", {31'b0, skey_ready}, 32'd0);
        chk("release keeps P20", P20, 32'hEE8B87BC);

        key_length = 4'd1;
        run_gen("len1", 1'b0);
        chk("len1 lit P1", P1, 32'h251C2FEF);
        chk("len1 lit P3", P3, 32'h123ACF49);
        release_en();

        key_length = 4'd0;
        run_gen("len0", 1'b0);
        chk("len0 lit P3", P3, 32'h123ACF49);
        release_en();

        for (int j = 0; j < 8; j++) kin[j] = 64'd0;
        key_length = 4'd8;
        run_gen("zero", 1'b0);
        chk("zero lit P1", P1, 32'h243F6A88);
        chk("zero lit P20", P20, 32'h98DFB5AC);
        release_en();

        set_plan_keys();
        key_length = 4'd15;
        run_gen("len15", 1'b0);
        release_en();

        // Abort after ten MIX writes: P1..P10 new, P11..P20 untouched.
        prev = dp;
        set_plan_keys();
        key_length = 4'd4;
        ks = kin;
        Enable = 1'b1;
        step();
        repeat (10) step();
        Enable = 1'b0;
        step();
        chk("abort ready", {31'b0, skey_ready}, 32'd0);
        repeat (3) step();
        chk("abort ready later", {31'b0, skey_ready}, 32'd0);
        chk("abort P10", P10, model_p(9, ks, 4'd4));
        chk("abort P11", P11, prev[10]);
        chk("abort P20", P20, prev[19]);
        run_gen("after abort", 1'b0);
        release_en();

        // Reset in MIX, then restart with keys changing mid-mix.
        set_plan_keys();
        key_length = 4'd3;
        Enable = 1'b1;
        step();
        repeat (5) step();
        Rst = 1'b1;
        step();
        check_zero("rst mix");
        Rst = 1'b0;
        run_gen("key change", 1'b1);

        Rst = 1'b1;
        step();
        check_zero("rst done");
        Rst = 1'b0;
        release_en();

        for (int n = 0; n < 6; n++) begin
            for (int j = 0; j < 8; j++) kin[j] = {$urandom, $urandom};
            key_length = 4'($urandom_range(0, 15));
            run_gen($sformatf("rand%0d", n), 1'b0);
            release_en();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blowfish128_skeygen.md
Name: blowfish128_skeygen

Overview:
- Blowfish-128 subkey generator, key-mixing stage.
- Loads the 20-entry P-array with the pi-digit constants XORed cyclically with the user key (up to 512 bits, 64-bit words).
- Sits ahead of the Blowfish-128 encrypt/decrypt datapath, which consumes P1..P20 once skey_ready is high.
- Sequential, one P entry per clock, keeping area small.

Parameters:
- NUM_P, 20, number of 32-bit P-array entries (fixed; ports are enumerated).
- MAX_KEY_WORDS, 8, maximum number of 64-bit key words.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous reset, active-high.
- Enable  input  1  level request to generate subkeys.
- key0..key7  input  64 each  user key words; key0 is first.
- key_length  input  4  number of valid 64-bit key words (1..8).
- skey_ready  output  1  P1..P20 are valid and stable.
- P1..P20  output  32 each  generated subkeys (registered).

Behaviour:
- Reset (Rst=1 at a rising edge): state=IDLE, P1..P20=0, skey_ready=0, index=0, latched key cleared. Rst has priority over all else.
- 32-bit key word sequence:
  - K[2j] = keyj[63:32], K[2j+1] = keyj[31:0], j=0..7.
  - Word count W = 2*L, where L = key_length clamped: 0 -> 1, 9..15 -> 8.
- Constants PI[1..20]: 243F6A88 85A308D3 13198A2E 03707344 A4093822 299F31D0 082EFA98 EC4E6C89 452821E6 38D01377 BE5466CF 34E90C6C C0AC29B7 C97C50DD 3F84D5B5 B5470917 9216D5D9 8979FB1B D1310BA6 98DFB5AC.
- Result: Pi = PI[i] XOR K[(i-1) mod W].
- FSM states IDLE, MIX, DONE.
  - IDLE: if Enable=1 at an edge, latch key0..key7 and the clamped L, set index=0, go to MIX. Otherwise hold; P outputs keep their last values.
  - MIX: each edge writes P[index+1] and increments index. The key-word pointer wraps to 0 when it reaches W. On the edge writing P20, go to DONE and set skey_ready=1.
  - MIX, Enable=0 at an edge: abort to IDLE with skey_ready=0. Partially written P values are retained but invalid.
  - DONE: skey_ready=1 while Enable=1. Enable=0 at an edge goes to IDLE, clears skey_ready, retains P.
- Latency: Enable sampled high at edge E0 (IDLE) gives P1 written at E1, P20 written and skey_ready high after edge E20.
- Key inputs are sampled only at the IDLE->MIX edge; changes during MIX or DONE are ignored. New keys require Enable low for at least one edge, then high again.
- skey_ready never asserts with a partially updated P-array.

Decomposition:
- Package blowfish128_pkg holds:
  - PI constant array (20 x 32-bit);
  - state enum {IDLE, MIX, DONE};
  - NUM_P and MAX_KEY_WORDS.
- One sub-module is natural: blowfish128_keyword_sel. It is a combinational mux from the latched key and pointer to K[ptr], and also owns the key_length clamp.
- FSM, index counter and P registers stay in the top module.

Test Plan:
- key_length=4, key0=0123456789ABCDEF, key1=FEDCBA9876543210, key2=0011223344556677, key3=8899AABBCCDDEEFF, Enable held 1 -> skey_ready high 20 cycles after the sampling edge; P1=251C2FEF, P2=0C08C53C, P9=440B6481, P20=EE8B87BC.
- Same keys with key_length=1 -> P1=251C2FEF, P3=123ACF49 (wrap after 2 words).
- All keys zero, key_length=8 -> P1..P20 equal the PI constants (P1=243F6A88, P20=98DFB5AC).
- key_length=0 and key_length=15 -> identical results to key_length=1 and key_length=8 respectively.
- Enable dropped at cycle 10 of MIX -> FSM returns to IDLE, skey_ready stays 0. Re-asserting Enable gives full correct P after 20 cycles.
- Rst asserted during MIX and during DONE -> next edge all P=0, skey_ready=0, state IDLE. Key change during MIX does not affect the results.
